// File: rtl/shift_add_sequencer.sv
// shift_add_sequencer
// Control and operand stage for a sequential shift-add multiplier. It accepts
// one unsigned operand pair, clears the downstream accumulator, then feeds it
// the shifted multiplicand once per multiplier bit (LSB first). It raises
// result_valid once the accumulator holds the product.
//
// Optional build macro: EARLY_TERM_EN
//   When defined, RUN also ends as soon as the remaining multiplier bits are
//   all zero, so iterations that would only add zero are skipped. A zero
//   multiplier still runs one RUN cycle.
//
// Every output is decoded from registered state and datapath only. No input
// reaches an output combinationally.

module shift_add_sequencer #(
  parameter int WIDTH_P = 32,
  parameter int OPW_P   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW_P-1:0]   multiplicand,
  input  logic [OPW_P-1:0]   multiplier,
  output logic               flush,
  output logic               add_shift,
  output logic [WIDTH_P-1:0] addend,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready
);

  localparam int CNT_W = $clog2(OPW_P + 1);

  // The full product must fit in the accumulator, or the result is silently
  // truncated. Catch that at elaboration time.
  generate
    if (WIDTH_P < 2 * OPW_P) begin : g_width_check
      $error("shift_add_sequencer: WIDTH_P must be >= 2*OPW_P");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH_P-1:0] r_mcand;
  logic [WIDTH_P-1:0] w_mcand_nxt;
  logic [OPW_P-1:0]   r_mplier;
  logic [OPW_P-1:0]   w_mplier_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;

  logic               w_count_last;
  logic               w_last_iter;

  // The last iteration is reached when the bit count runs out. With early
  // termination it is also reached when no set multiplier bits remain.
  assign w_count_last = (r_count == CNT_W'(OPW_P - 1));

`ifdef EARLY_TERM_EN
  logic w_rest_zero;
  assign w_rest_zero = ((r_mplier >> 1) == '0);
  assign w_last_iter = w_count_last | w_rest_zero;
`else
  assign w_last_iter = w_count_last;
`endif

  // Next-state and next-datapath logic for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case, so paths that do
    // not assign it hold the old value instead of inferring a latch.
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_count_nxt  = r_count;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_mcand_nxt  = WIDTH_P'(multiplicand);
          w_mplier_nxt = multiplier;
          w_count_nxt  = '0;
          w_state_nxt  = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        w_state_nxt = ST_RUN;
      end

      ST_RUN: begin
        // Bits shifted past the top of the accumulator width are dropped.
        // This cannot lose product bits, because WIDTH_P >= 2*OPW_P.
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_count_nxt  = r_count + CNT_W'(1);
        if (w_last_iter) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        if (result_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the operand registers are reset along with the state. A
    // freshly reset block then shows the same internal values every time,
    // even though IDLE never reads them.
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values of the others, whatever the statement order.
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Output decode from registered state and datapath only.
  always_comb begin
    in_ready     = 1'b0;
    flush        = 1'b0;
    add_shift    = 1'b0;
    addend       = '0;
    busy         = 1'b0;
    result_valid = 1'b0;

    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_CLEAR: begin
        flush = 1'b1;
        busy  = 1'b1;
      end
      ST_RUN: begin
        // addend carries the shifted multiplicand on every RUN cycle.
        // add_shift alone decides whether the accumulator uses it.
        addend    = r_mcand;
        add_shift = r_mplier[0];
        busy      = 1'b1;
      end
      ST_DONE: begin
        result_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // A clear and an add never happen on the same accumulator cycle.
  a_no_flush_and_add : assert property (
    @(posedge clk) disable iff (reset) !(flush && add_shift)
  );

  // Exactly one of the state-level status outputs is high in every state.
  a_status_onehot : assert property (
    @(posedge clk) disable iff (reset)
      $onehot({in_ready, busy, result_valid})
  );

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Self-checking bench for shift_add_sequencer.
// The bench holds a behavioural accumulator that reacts to flush, add_shift
// and addend. Each cycle is compared with the sequence that follows from the
// multiply rules: a clear cycle, then one cycle per multiplier bit carrying
// multiplicand<<i, then DONE. The final product is compared with a*b.
// Compile with +define+EARLY_TERM_EN to check the early-termination build.

module tb_shift_add_sequencer;

  localparam int W = 32;
  localparam int N = 16;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic         flush;
  logic         add_shift;
  logic [W-1:0] addend;
  logic         busy;
  logic         result_valid;
  logic         result_ready;

  int           n_vec = 0;
  int           n_bad = 0;
  logic [W-1:0] acc;

  shift_add_sequencer #(.WIDTH_P(W), .OPW_P(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .flush        (flush),
    .add_shift    (add_shift),
    .addend       (addend),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observable output bundle {flush, add_shift, addend, busy, result_valid, in_ready}.
  function automatic logic [W+4:0] obs_bundle();
    return {flush, add_shift, addend, busy, result_valid, in_ready};
  endfunction

  function automatic logic [W+4:0] exp_bundle(input logic f, input logic a,
                                              input logic [W-1:0] ad, input logic b,
                                              input logic rv, input logic ir);
    return {f, a, ad, b, rv, ir};
  endfunction

  // Number of RUN cycles the sequencer should spend on a given multiplier.
  function automatic int exp_runs(input logic [N-1:0] b);
`ifdef EARLY_TERM_EN
    int hi;
    hi = 0;
    for (int i = 0; i < N; i++) if (b[i]) hi = i + 1;
    return (hi == 0) ? 1 : hi;
`else
    return N;
`endif
  endfunction

  // Behavioural accumulator: reacts to the cycle's control outputs.
  task automatic acc_step();
    if (flush) acc = '0;
    else if (add_shift) acc = acc + addend;
  endtask

  // One complete multiply. Call at a negedge with the DUT in IDLE.
  // hold: DONE cycles with result_ready low. junk: offer new operands during DONE.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input int hold, input bit junk);
    int           runs;
    logic [W-1:0] exp_prod;
    logic [W-1:0] shifted;
    runs     = exp_runs(b);
    exp_prod = W'(a) * W'(b);
    check("idle_before_accept", obs_bundle(), exp_bundle(0, 0, '0, 0, 0, 1));
    in_valid     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    result_ready = 1'($urandom);
    @(negedge clk);
    for (int c = 0; c < 1 + runs; c++) begin
      if (c == 0) begin
        check("clear_cycle", obs_bundle(), exp_bundle(1, 0, '0, 1, 0, 0));
      end else begin
        shifted = W'(a) << (c - 1);
        check($sformatf("run_cycle%0d a=%0h b=%0h", c - 1, a, b), obs_bundle(),
              exp_bundle(0, b[c-1], shifted, 1, 0, 0));
      end
      acc_step();
      // Inputs other than at accept must be ignored, so scramble them.
      in_valid     = 1'($urandom);
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      result_ready = 1'($urandom);
      @(negedge clk);
    end
    check($sformatf("done_entry a=%0h b=%0h", a, b), obs_bundle(),
          exp_bundle(0, 0, '0, 0, 1, 0));
    check($sformatf("product %0h*%0h", a, b), acc, exp_prod);
    acc_step();
    result_ready = 1'b0;
    in_valid     = junk;
    if (junk) begin
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("done_hold", obs_bundle(), exp_bundle(0, 0, '0, 0, 1, 0));
      acc_step();
      check("acc_hold", acc, exp_prod);
    end
    result_ready = 1'b1;
    @(negedge clk);
    // The release edge must not accept, even with in_valid held high.
    check("idle_after_release", obs_bundle(), exp_bundle(0, 0, '0, 0, 0, 1));
    in_valid     = 1'b0;
    result_ready = 1'b0;
  endtask

  // Reset in the RUN cycle with count=7: outputs drop at once, before any clock edge.
  task automatic reset_mid_run();
    logic [N-1:0] a;
    logic [W-1:0] shifted;
    a            = N'($urandom) | N'(1);
    in_valid     = 1'b1;
    multiplicand = a;
    multiplier   = '1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) @(negedge clk);
    shifted = W'(a) << 7;
    check("run_count7", obs_bundle(), exp_bundle(0, 1, shifted, 1, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", obs_bundle(), exp_bundle(0, 0, '0, 0, 0, 1));
    acc = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(16'd2, 16'd7, 0, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    result_ready = 1'b0;
    acc          = '0;
    #1;
    check("reset_outputs", obs_bundle(), exp_bundle(0, 0, '0, 0, 0, 1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(16'd3, 16'd5, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    do_op(16'h1234, 16'h0000, 1, 1'b0);
    do_op(N'($urandom), N'($urandom), 10, 1'b1);
    reset_mid_run();
    do_op(N'($urandom), 16'd5, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = N'($urandom);
      case ($urandom_range(0, 3))
        0:       b = N'($urandom);
        1:       b = N'($urandom) >> $urandom_range(1, N - 1);
        2:       b = N'(1) << $urandom_range(0, N - 1);
        default: b = '1;
      endcase
      do_op(a, b, $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
